trng_byte_feeder: RTL and testbench

- Upstream stage of the PC link serializer (LVDS data/clock/sync sender).
- Collects raw TRNG bits from the entropy sampler, packs them MSB-first into bytes and buffers the bytes in a small synchronous FIFO.
- Issues one-cycle transmit requests to the serializer, paced by its is_transmitting busy flag.
- Drops bytes when the buffer is full and reports the drop.

---
 rtl/trng_feeder_pkg.sv | 14 +
 rtl/trng_byte_feeder_if.sv | 12 +
 rtl/trng_byte_feeder_byte_fifo.sv | 48 ++++
 rtl/trng_byte_feeder.sv | 142 ++++++++++++++
 tb/tb_trng_byte_feeder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/trng_feeder_pkg.sv
// Shared types and constants for the TRNG byte feeder.
package trng_feeder_pkg;

    localparam int BYTE_W       = 8;
    localparam int BUSY_TIMEOUT = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sendState_t;

endpackage

// File: rtl/trng_byte_feeder_if.sv
// Handshake between the byte feeder and the link serializer.
interface trng_byte_feeder_if;
    import trng_feeder_pkg::*;

    logic              transmit;
    logic [BYTE_W-1:0] tx_byte;
    logic              is_transmitting;

    modport master (output transmit, output tx_byte, input is_transmitting);
    modport slave  (input transmit, input tx_byte, output is_transmitting);

endinterface

// File: rtl/trng_byte_feeder_byte_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; a pop frees its slot for a
// push in the same cycle, so push+pop while full is accepted.
module byte_fifo
    import trng_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);
    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW:0]       wrPtr;
    logic [AW:0]       rdPtr;
    logic              doPush;
    logic              doPop;

    assign level  = wrPtr - rdPtr;
    assign full   = (level == (AW+1)'(DEPTH));
    assign empty  = (level == '0);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign dout   = mem[rdPtr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
            if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/trng_byte_feeder.sv
// TRNG byte feeder: packs raw bits MSB-first into bytes, buffers them and
// hands them one at a time to the link serializer.
// Optional build macro TRNG_FEEDER_DROPCNT_EN adds a saturating drop counter.
//
// Sender FSM
//   state     | meaning
//   IDLE      | wait for a buffered byte and an idle serializer; pop head
//   REQ       | transmit high for this one cycle, tx_byte valid
//   WAIT_BUSY | wait up to BUSY_TIMEOUT cycles for the serializer to go busy
//   WAIT_DONE | serializer busy with the frame; wait for it to drop busy
module trng_byte_feeder
    import trng_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               rnd_bit,
    input  logic               rnd_valid,
    trng_byte_feeder_if.master ser,
    output logic [AW:0]        fifo_level,
    output logic               overflow
`ifdef TRNG_FEEDER_DROPCNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);
    logic [2:0]        bitCnt;
    logic [BYTE_W-2:0] shiftReg;
    logic [BYTE_W-1:0] packedByte;
    logic [BYTE_W-1:0] headByte;
    logic [BYTE_W-1:0] txByteReg;
    logic              take;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [1:0]        busyTmr;
    sendState_t        state;
    sendState_t        stateNext;

    // The byte completes combinationally so it is pushed in the 8th bit's cycle.
    assign take       = en && rnd_valid;
    assign packedByte = {shiftReg, rnd_bit};
    assign push       = take && (bitCnt == 3'd7);
    assign drop       = push && fifoFull && !pop;

    // Bit packer: shift in at the LSB, so the first bit lands in bit 7
    always_ff @(posedge clk) begin
        if (rst) begin
            bitCnt   <= '0;
            shiftReg <= '0;
        end else if (take) begin
            bitCnt   <= bitCnt + 3'd1;
            shiftReg <= packedByte[BYTE_W-2:0];
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) uFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (packedByte),
        .pop   (pop),
        .dout  (headByte),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .level (fifo_level)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // FSM next state and pop decision
    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifoEmpty && !ser.is_transmitting) begin
                    pop       = 1'b1;
                    stateNext = REQ;
                end
            end
            REQ:       stateNext = WAIT_BUSY;
            WAIT_BUSY: begin
                if (ser.is_transmitting) stateNext = WAIT_DONE;
                else if (busyTmr == '0)  stateNext = IDLE;
            end
            WAIT_DONE: begin
                if (!ser.is_transmitting) stateNext = IDLE;
            end
            default:   stateNext = IDLE;
        endcase
    end

    // Busy-wait down-counter, loaded while the request is on the wire
    always_ff @(posedge clk) begin
        if (rst)                                   busyTmr <= '0;
        else if (state == REQ)                     busyTmr <= 2'(BUSY_TIMEOUT - 1);
        else if (state == WAIT_BUSY && busyTmr != '0) busyTmr <= busyTmr - 2'd1;
    end

    // Popped byte is held until the next pop
    always_ff @(posedge clk) begin
        if (rst)      txByteReg <= '0;
        else if (pop) txByteReg <= headByte;
    end

    assign ser.transmit = (state == REQ);
    assign ser.tx_byte  = txByteReg;

`ifdef TRNG_FEEDER_DROPCNT_EN
    // Saturating count of bytes dropped on a full buffer
    always_ff @(posedge clk) begin
        if (rst)                              drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end

    assign overflow = (drop_cnt != '0);
`else
    logic overflowReg;

    // Sticky drop flag
    always_ff @(posedge clk) begin
        if (rst)       overflowReg <= 1'b0;
        else if (drop) overflowReg <= 1'b1;
    end

    assign overflow = overflowReg;
`endif

endmodule

// File: tb/tb_trng_byte_feeder.sv
// Bench for trng_byte_feeder: directed bit streams, a serializer model with
// normal / stuck-busy / never-busy behaviour, and a queue-based reference.
module tb_trng_byte_feeder;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int SER_NORMAL = 0;
    localparam int SER_STUCK  = 1;
    localparam int SER_DEAD   = 2;

    logic          clk;
    logic          rst;
    logic          en;
    logic          rnd_bit;
    logic          rnd_valid;
    logic [AW:0]   fifo_level;
    logic          overflow;
`ifdef TRNG_FEEDER_DROPCNT_EN
    logic [15:0]   drop_cnt;
`endif

    trng_byte_feeder_if sif();

    trng_byte_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rnd_bit    (rnd_bit),
        .rnd_valid  (rnd_valid),
        .ser        (sif.master),
        .fifo_level (fifo_level),
        .overflow   (overflow)
`ifdef TRNG_FEEDER_DROPCNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int stepNo = 0;
    int serMode;
    int busyLeft;

    // Reference model state
    logic [7:0] mq [$];
    logic [7:0] mAcc;
    int         mBits;
    int         mLastPop;
    logic       mTransmit;
    logic [7:0] mTxByte;
    int         mDrops;
    bit         busyHist [0:4095];
    int         txLogEdge [$];
    logic [7:0] txLogByte [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at step %0d: got %0h want %0h", nm, stepNo, act, exp);
        end
    endtask

    // Sender may pop at edge e once the previous request is finished: either
    // busy never showed in the two sampling edges (timeout), or busy showed
    // and has since been seen low.
    function automatic bit senderFree(input int e);
        int b;
        if (mLastPop < 0) return 1'b1;
        b = -1;
        for (int k = mLastPop + 2; k <= mLastPop + 3 && k <= e; k++)
            if (busyHist[k] && b < 0) b = k;
        if (b < 0) return (e >= mLastPop + 4);
        for (int k = b + 1; k < e; k++)
            if (!busyHist[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelStep(input int e);
        bit busyNow;
        busyNow = sif.is_transmitting;
        busyHist[e] = busyNow;
        if (rst) begin
            mq.delete();
            mAcc = '0; mBits = 0; mLastPop = -1;
            mTransmit = 1'b0; mTxByte = '0; mDrops = 0;
            return;
        end
        mTransmit = 1'b0;
        if (mq.size() > 0 && !busyNow && senderFree(e)) begin
            mTxByte   = mq.pop_front();
            mTransmit = 1'b1;
            mLastPop  = e;
            txLogEdge.push_back(e);
            txLogByte.push_back(mTxByte);
        end
        if (en && rnd_valid) begin
            mAcc = {mAcc[6:0], rnd_bit};
            mBits++;
            if (mBits == 8) begin
                mBits = 0;
                if (mq.size() < DEPTH) mq.push_back(mAcc);
                else mDrops++;
            end
        end
    endtask

    task automatic compareOutputs();
        check("transmit",   32'(sif.transmit), 32'(mTransmit));
        check("tx_byte",    32'(sif.tx_byte),  32'(mTxByte));
        check("fifo_level", 32'(fifo_level),   32'(mq.size()));
        check("overflow",   32'(overflow),     32'(mDrops > 0));
        check("tx_while_busy", 32'(sif.transmit & sif.is_transmitting), 32'd0);
`ifdef TRNG_FEEDER_DROPCNT_EN
        check("drop_cnt", 32'(drop_cnt), (mDrops > 65535) ? 32'hFFFF : 32'(mDrops));
`endif
    endtask

    // One clock: model the edge just taken, compare, then drive the next inputs.
    task automatic step(input logic r, input logic e, input logic v, input logic b);
        @(negedge clk);
        stepNo++;
        modelStep(stepNo);
        compareOutputs();
        rst = r; en = e; rnd_valid = v; rnd_bit = b;
        case (serMode)
            SER_STUCK: sif.is_transmitting = 1'b1;
            SER_DEAD:  sif.is_transmitting = 1'b0;
            default: begin
                if (busyLeft > 0) begin
                    sif.is_transmitting = 1'b1;
                    busyLeft--;
                end else begin
                    sif.is_transmitting = 1'b0;
                end
                if (sif.transmit) busyLeft = 8;
            end
        endcase
    endtask

    task automatic feedByte(input logic [7:0] val);
        for (int i = 7; i >= 0; i--) step(1'b0, 1'b1, 1'b1, val[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clearLog();
        txLogEdge.delete();
        txLogByte.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lastBit;
        rst = 1'b1; en = 1'b0; rnd_valid = 1'b0; rnd_bit = 1'b0;
        sif.is_transmitting = 1'b0;
        serMode = SER_NORMAL; busyLeft = 0;
        mLastPop = -1; mBits = 0; mDrops = 0; mAcc = '0;
        mTransmit = 1'b0; mTxByte = '0;

        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Single byte 1,0,1,1,0,0,1,0 -> B2, request in the third cycle
        // counting the last bit's own cycle.
        clearLog();
        feedByte(8'hB2);
        lastBit = stepNo;
        idle(20);
        check("b2_count", 32'(txLogByte.size()), 32'd1);
        if (txLogByte.size() >= 1) begin
            check("b2_byte",    32'(txLogByte[0]), 32'hB2);
            check("b2_latency", 32'(txLogEdge[0] - lastBit), 32'd2);
        end

        // Packing disabled while rnd_valid toggles
        clearLog();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'(i % 2), 1'(i % 3 == 0));
        check("en0_no_tx", 32'(txLogByte.size()), 32'd0);
        check("en0_level", 32'(fifo_level), 32'd0);

        // Four back-to-back bytes, one request per 11 cycles
        clearLog();
        for (int k = 1; k <= 4; k++) feedByte(8'(k));
        idle(50);
        check("b2b_count", 32'(txLogByte.size()), 32'd4);
        if (txLogByte.size() == 4) begin
            for (int k = 0; k < 4; k++) check("b2b_byte", 32'(txLogByte[k]), 32'(k + 1));
            for (int k = 1; k < 4; k++)
                check("b2b_spacing", 32'(txLogEdge[k] - txLogEdge[k-1]), 32'd11);
        end
        check("b2b_no_drop", 32'(mDrops), 32'd0);

        // Serializer stuck busy: 17 bytes into 16 slots
        serMode = SER_STUCK;
        idle(2);
        clearLog();
        for (int k = 1; k <= DEPTH + 1; k++) feedByte(8'(k));
        idle(3);
        check("full_level", 32'(mq.size()), 32'd16);
        check("full_drops", 32'(mDrops), 32'd1);
        check("full_no_tx", 32'(txLogByte.size()), 32'd0);

        // Reset with two bytes queued and five bits packed
        step(1'b1, 1'b0, 1'b0, 1'b0);
        feedByte(8'hAA);
        feedByte(8'h55);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_level",    32'(fifo_level),   32'd0);
        check("rst_overflow", 32'(overflow),     32'd0);
        check("rst_tx_byte",  32'(sif.tx_byte),  32'd0);
        serMode = SER_NORMAL;
        idle(2);
        clearLog();
        feedByte(8'h5A);
        idle(20);
        check("post_rst_count", 32'(txLogByte.size()), 32'd1);
        if (txLogByte.size() >= 1) check("post_rst_byte", 32'(txLogByte[0]), 32'h5A);

        // Serializer that never goes busy: timeout, then next byte
        serMode = SER_STUCK;
        idle(2);
        feedByte(8'hC3);
        feedByte(8'h3C);
        idle(1);
        clearLog();
        serMode = SER_DEAD;
        idle(15);
        check("dead_count", 32'(txLogByte.size()), 32'd2);
        if (txLogByte.size() == 2) begin
            check("dead_byte0",   32'(txLogByte[0]), 32'hC3);
            check("dead_byte1",   32'(txLogByte[1]), 32'h3C);
            check("dead_spacing", 32'(txLogEdge[1] - txLogEdge[0]), 32'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
